// File: rtl/grf_writeback_pkg.sv
// Shared definitions for the register file / write-back block.
//   - default widths
//   - RegDst and MemtoReg select encodings
//   - index of the link register ($31)
package grf_writeback_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Destination register select
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;
    localparam logic [1:0] REGDST_NONE = 2'b11;

    // Write-back data select; 2'b11 falls back to the ALU result
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam int unsigned REG_RA = 31;

endpackage

// File: rtl/grf_core.sv
// Register array with two combinational read ports and one write port.
//   clk, reset        : clock, asynchronous active-high reset (clears every register)
//   we, waddr, wdata  : write request; a write to register 0 is dropped
//   raddr1, raddr2    : read addresses
//   rdata1, rdata2    : read data; register 0 always reads 0
// With BYPASS=1 a write pending this cycle is forwarded to a matching read port.
module grf_core
    import grf_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    assign commit = we && (waddr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end

    // Address 0 is checked first so neither storage nor forwarding can leak into $0.
    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if ((BYPASS != 0) && commit && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if ((BYPASS != 0) && commit && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/grf_writeback.sv
// Register file plus write-back selection for the single-cycle MIPS datapath.
//   clk, reset          : clock, asynchronous active-high reset
//   RegWrite            : write enable for the current instruction
//   RegDst              : destination select (Rt / Rd / $31 / none)
//   MemtoReg            : write data select (ALU / memory / PC+4 / ALU)
//   Rs, Rt, Rd          : register indices
//   ALUResult, MemData  : write-back data candidates
//   PC                  : PC of the current instruction
//   RData1, RData2      : read operands for Rs and Rt
//   WAddr, WData        : selected destination and write data (combinational)
//   trace_*             : registered one-cycle event per committed write
module grf_writeback
    import grf_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [1:0]        RegDst,
    input  logic [1:0]        MemtoReg,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemData,
    input  logic [31:0]       PC,
    output logic [DATA_W-1:0] RData1,
    output logic [DATA_W-1:0] RData2,
    output logic [ADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0] WData,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
);

    logic [31:0] pc_plus4;
    logic        commit;

    // Wraps naturally at 2**32
    assign pc_plus4 = PC + 32'd4;

    always_comb begin
        WAddr = '0;
        case (RegDst)
            REGDST_RT:   WAddr = Rt;
            REGDST_RD:   WAddr = Rd;
            REGDST_RA:   WAddr = ADDR_W'(REG_RA);
            default:     WAddr = '0;  // REGDST_NONE: address 0 means no write
        endcase
    end

    always_comb begin
        WData = ALUResult;
        case (MemtoReg)
            WB_MEM:  WData = MemData;
            WB_PC4:  WData = DATA_W'(pc_plus4);
            default: WData = ALUResult;
        endcase
    end

    assign commit = RegWrite && (WAddr != '0);

    grf_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .we     (RegWrite),
        .waddr  (WAddr),
        .wdata  (WData),
        .raddr1 (Rs),
        .raddr2 (Rt),
        .rdata1 (RData1),
        .rdata2 (RData2)
    );

    // Fields only move on a commit so they keep the last event while valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else if (commit) begin
            trace_valid <= 1'b1;
            trace_pc    <= PC;
            trace_addr  <= WAddr;
            trace_data  <= WData;
        end else begin
            trace_valid <= 1'b0;
        end
    end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- General register file plus write-back selection for the single-cycle MIPS datapath.
- Supplies the two register read operands: RData1 goes to ALU A; RData2 goes to the ALU-B operand mux and to data-memory write data.
- Takes the write-back end of the same path: selects the destination register and the write data, then commits on the clock edge.
- Emits a registered one-cycle trace event per committed write for the grading bench.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register index width
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to the read port; 0 = reads return the pre-write value

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- RegWrite  input  1  write enable for this instruction
- RegDst  input  2  destination select: 00 Rt, 01 Rd, 10 $31, 11 no write
- MemtoReg  input  2  data select: 00 ALUResult, 01 MemData, 10 PC+4, 11 ALUResult
- Rs  input  ADDR_W  read address 1
- Rt  input  ADDR_W  read address 2 / Rt destination
- Rd  input  ADDR_W  Rd destination
- ALUResult  input  DATA_W  ALU output
- MemData  input  DATA_W  data-memory read data
- PC  input  32  PC of the current instruction
- RData1  output  DATA_W  value of register Rs
- RData2  output  DATA_W  value of register Rt
- WAddr  output  ADDR_W  combinational selected destination
- WData  output  DATA_W  combinational selected write data
- trace_valid  output  1  one-cycle pulse, one cycle after a committed write
- trace_pc  output  32  PC of the committed write
- trace_addr  output  ADDR_W  register written
- trace_data  output  DATA_W  value written

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits.
- Register 0 is hardwired to zero: reads always return 0; writes are discarded.
- Reset: asynchronous, active-high. All registers clear to 0; trace_valid, trace_pc, trace_addr and trace_data clear to 0 immediately and stay 0 while reset is held.
- Reset mid-operation: any write whose edge coincides with asserted reset is lost and produces no trace event.
- Destination: WAddr = Rt / Rd / 31 per RegDst. RegDst=11 drives WAddr=0, i.e. no write.
- Write data:
  - WData = ALUResult, MemData or PC+4 per MemtoReg; MemtoReg=11 selects ALUResult.
  - PC+4 is computed mod 2**32 (PC=FFFFFFFC gives 00000000).
- Commit condition: RegWrite=1 and WAddr!=0. The register WAddr takes WData on the rising edge of clk.
- Trace:
  - On every commit edge: trace_valid=1, trace_pc=PC, trace_addr=WAddr, trace_data=WData.
  - trace_valid returns to 0 on the next edge unless another commit occurs; back-to-back commits keep it high with updated fields.
  - trace_pc/trace_addr/trace_data hold their last values when trace_valid=0.
  - A discarded write (address 0 or RegDst=11) produces no event.
- Reads: combinational, zero latency.
  - BYPASS=1: if commit condition holds and the read address equals WAddr (non-zero), the port returns WData in the same cycle.
  - BYPASS=0: the port returns the stored value until the edge.
- Simultaneous events:
  - Rs==Rt: both ports return the same value.
  - Rs==Rt==WAddr with BYPASS=1: both ports forward.
- No X propagation: all select encodings are defined.

Decomposition:
- Shared package/header holds:
  - RegDst encodings: REGDST_RT, REGDST_RD, REGDST_RA, REGDST_NONE.
  - MemtoReg encodings: WB_ALU, WB_MEM, WB_PC4.
  - REG_RA=31.
  - DATA_W/ADDR_W defaults.
- One natural sub-module, grf_core: register array, $0 rule, bypass and read ports.
- The top level grf_writeback adds destination/data select and the trace register.

Test Plan:
1. Reset with all registers pre-written to A5A5A5A5 -> every read returns 0 and trace_valid=0 immediately, before any clock edge.
2. RegWrite=1, RegDst=01, Rd=8, MemtoReg=00, ALUResult=12345678, PC=00003000 -> next cycle trace_valid=1, trace_pc=00003000, trace_addr=8, trace_data=12345678; Rs=8 then reads 12345678.
3. RegDst=10, MemtoReg=10, PC=00003010 -> $31=00003014; repeat with RegDst=00, Rt=0, ALUResult=FFFFFFFF -> $0 still reads 0 and no trace pulse.
4. BYPASS=1, Rs=Rt=Rd=9, RegDst=01, MemtoReg=01, MemData=DEADBEEF, RegWrite=1 -> RData1=RData2=DEADBEEF in the same cycle. BYPASS=0 -> old value (0) until the edge.
5. Three back-to-back writes to $1,$2,$3 with data 1,2,3 -> trace_valid high three consecutive cycles with matching addr/data, low on the fourth.
6. Assert reset asynchronously between edges during a write cycle to $5=77777777 -> $5 reads 0 and no trace event is produced.
